// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipe.
// Latches decode, forwards EX/MEM and MEM/WB, detects load-use.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_AND
`define ALU_AND 4'b0000
`define ALU_OR  4'b0001
`define ALU_ADD 4'b0010
`define ALU_SLL 4'b0011
`define ALU_SRL 4'b0100
`define ALU_SUB 4'b0110
`define ALU_SLT 4'b0111
`endif

module id_ex_stage #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int REG_AW     = 5
) (
  input  logic                  clk_87,
  input  logic                  rst_n_87,
  input  logic                  id_valid_87,
  input  logic [DATA_WIDTH-1:0] id_rs_data_87,
  input  logic [DATA_WIDTH-1:0] id_rt_data_87,
  input  logic [DATA_WIDTH-1:0] id_imm_87,
  input  logic [4:0]            id_shamt_87,
  input  logic [REG_AW-1:0]     id_rs_87,
  input  logic [REG_AW-1:0]     id_rt_87,
  input  logic [REG_AW-1:0]     id_rd_87,
  input  logic [3:0]            id_alu_op_87,
  input  logic                  id_use_imm_87,
  input  logic                  id_shift_87,
  input  logic                  id_uses_rt_87,
  input  logic                  id_reg_write_87,
  input  logic                  id_mem_read_87,
  input  logic                  id_mem_write_87,
  input  logic                  stall_87,
  input  logic                  flush_87,
  input  logic                  exm_reg_write_87,
  input  logic [REG_AW-1:0]     exm_rd_87,
  input  logic [DATA_WIDTH-1:0] exm_rslt_87,
  input  logic                  mwb_reg_write_87,
  input  logic [REG_AW-1:0]     mwb_rd_87,
  input  logic [DATA_WIDTH-1:0] mwb_data_87,
  output logic                  hazard_87,
  output logic                  ex_valid_87,
  output logic [DATA_WIDTH-1:0] arg_a_87,
  output logic [DATA_WIDTH-1:0] arg_b_87,
  output logic [3:0]            alu_op_87,
  output logic [DATA_WIDTH-1:0] ex_store_data_87,
  output logic [REG_AW-1:0]     ex_rd_87,
  output logic                  ex_reg_write_87,
  output logic                  ex_mem_read_87,
  output logic                  ex_mem_write_87
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            shamt;
    logic [REG_AW-1:0]     rs;
    logic [REG_AW-1:0]     rt;
    logic [REG_AW-1:0]     rd;
    logic [3:0]            alu_op;
    logic                  use_imm;
    logic                  shift;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

  id_ex_t ex_q, ex_d, id_in;

  logic rs_hit, rt_hit;
  logic exm_rs, exm_rt, mwb_rs, mwb_rt;
  logic [DATA_WIDTH-1:0] fwd_rs, fwd_rt, shamt_ext;

  assign rs_hit = ex_q.rd == id_rs_87;
  assign rt_hit = id_uses_rt_87 && (ex_q.rd == id_rt_87);

  assign hazard_87 = id_valid_87 && ex_q.valid && ex_q.mem_read &&
                     (ex_q.rd != '0) && (rs_hit || rt_hit);

  always_comb begin
    id_in           = '0;
    id_in.valid     = id_valid_87;
    id_in.rs_data   = id_rs_data_87;
    id_in.rt_data   = id_rt_data_87;
    id_in.imm       = id_imm_87;
    id_in.shamt     = id_shamt_87;
    id_in.rs        = id_rs_87;
    id_in.rt        = id_rt_87;
    id_in.rd        = id_rd_87;
    id_in.alu_op    = id_alu_op_87;
    id_in.use_imm   = id_use_imm_87;
    id_in.shift     = id_shift_87;
    id_in.reg_write = id_reg_write_87 && id_valid_87;
    id_in.mem_read  = id_mem_read_87 && id_valid_87;
    id_in.mem_write = id_mem_write_87 && id_valid_87;
  end

  // flush beats stall so a squashed slot never survives a freeze
  always_comb begin
    ex_d = ex_q;
    priority case (1'b1)
      flush_87:  ex_d = '0;
      stall_87:  ex_d = ex_q;
      hazard_87: ex_d = '0;
      default:   ex_d = id_in;
    endcase
  end

  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) ex_q <= '0;
    else           ex_q <= ex_d;
  end

  assign exm_rs = exm_reg_write_87 && (exm_rd_87 != '0) &&
                  (exm_rd_87 == ex_q.rs);
  assign exm_rt = exm_reg_write_87 && (exm_rd_87 != '0) &&
                  (exm_rd_87 == ex_q.rt);
  assign mwb_rs = mwb_reg_write_87 && (mwb_rd_87 != '0) &&
                  (mwb_rd_87 == ex_q.rs);
  assign mwb_rt = mwb_reg_write_87 && (mwb_rd_87 != '0) &&
                  (mwb_rd_87 == ex_q.rt);

  assign fwd_rs = exm_rs ? exm_rslt_87 :
                  mwb_rs ? mwb_data_87 : ex_q.rs_data;
  assign fwd_rt = exm_rt ? exm_rslt_87 :
                  mwb_rt ? mwb_data_87 : ex_q.rt_data;

  assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, ex_q.shamt};

  assign arg_a_87 = ex_q.shift ? fwd_rt : fwd_rs;
  assign arg_b_87 = ex_q.shift   ? shamt_ext :
                    ex_q.use_imm ? ex_q.imm  : fwd_rt;

  assign ex_store_data_87 = fwd_rt;
  assign ex_valid_87      = ex_q.valid;
  assign alu_op_87        = ex_q.alu_op;
  assign ex_rd_87         = ex_q.rd;
  assign ex_reg_write_87  = ex_q.reg_write;
  assign ex_mem_read_87   = ex_q.mem_read;
  assign ex_mem_write_87  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, hand sequences and
// randomized traffic against a behavioural pipeline model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        use_imm;
    logic        shift;
    logic        uses_rt;
    logic        rw;
    logic        mr;
    logic        mw;
  } dec_t;

  typedef struct {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_imm;
    logic        shift;
    logic        exm_rw;
    logic [4:0]  exm_rd;
    logic [31:0] exm_rslt;
    logic        mwb_rw;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] esd;
  } vec_t;

  logic clk, rst_n, stall, flush;
  dec_t d, m;
  logic        exm_rw, mwb_rw;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_rslt, mwb_data;

  logic        hazard, ex_valid, ex_rw, ex_mr, ex_mw;
  logic [31:0] arg_a, arg_b, sdata;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;

  int ncmp = 0;
  int nfail = 0;
  vec_t vt[8];

  id_ex_stage dut (
    .clk_87(clk), .rst_n_87(rst_n),
    .id_valid_87(d.valid),
    .id_rs_data_87(d.rs_data), .id_rt_data_87(d.rt_data),
    .id_imm_87(d.imm), .id_shamt_87(d.shamt),
    .id_rs_87(d.rs), .id_rt_87(d.rt), .id_rd_87(d.rd),
    .id_alu_op_87(d.op), .id_use_imm_87(d.use_imm),
    .id_shift_87(d.shift), .id_uses_rt_87(d.uses_rt),
    .id_reg_write_87(d.rw), .id_mem_read_87(d.mr),
    .id_mem_write_87(d.mw),
    .stall_87(stall), .flush_87(flush),
    .exm_reg_write_87(exm_rw), .exm_rd_87(exm_rd),
    .exm_rslt_87(exm_rslt),
    .mwb_reg_write_87(mwb_rw), .mwb_rd_87(mwb_rd),
    .mwb_data_87(mwb_data),
    .hazard_87(hazard), .ex_valid_87(ex_valid),
    .arg_a_87(arg_a), .arg_b_87(arg_b), .alu_op_87(alu_op),
    .ex_store_data_87(sdata), .ex_rd_87(ex_rd),
    .ex_reg_write_87(ex_rw), .ex_mem_read_87(ex_mr),
    .ex_mem_write_87(ex_mw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // A load in EX blocks a dependent decode for one slot
  function automatic logic model_hz();
    if (!d.valid || !m.valid || !m.mr || m.rd == 5'd0) return 1'b0;
    return (m.rd == d.rs) || (d.uses_rt && m.rd == d.rt);
  endfunction

  function automatic logic [31:0] model_fwd(logic [4:0] a,
                                            logic [31:0] r);
    if (a == 5'd0) return r;
    if (exm_rw && exm_rd == a) return exm_rslt;
    if (mwb_rw && mwb_rd == a) return mwb_data;
    return r;
  endfunction

  task automatic tick();
    dec_t nx;
    if (!rst_n || flush) nx = '0;
    else if (stall) nx = m;
    else if (model_hz()) nx = '0;
    else begin
      nx = d;
      nx.uses_rt = 1'b0;
      nx.rw = d.rw & d.valid;
      nx.mr = d.mr & d.valid;
      nx.mw = d.mw & d.valid;
    end
    @(posedge clk);
    #1;
    m = nx;
  endtask

  task automatic check_outputs(string t);
    logic [31:0] a, b, rt;
    rt = model_fwd(m.rt, m.rt_data);
    a = m.shift ? rt : model_fwd(m.rs, m.rs_data);
    b = m.shift ? {27'd0, m.shamt} : (m.use_imm ? m.imm : rt);
    chk({t, " arg_a"}, arg_a, a);
    chk({t, " arg_b"}, arg_b, b);
    chk({t, " store"}, sdata, rt);
    chk({t, " valid"}, 32'(ex_valid), 32'(m.valid));
    chk({t, " op"}, 32'(alu_op), 32'(m.op));
    chk({t, " rd"}, 32'(ex_rd), 32'(m.rd));
    chk({t, " rw"}, 32'(ex_rw), 32'(m.rw));
    chk({t, " mr"}, 32'(ex_mr), 32'(m.mr));
    chk({t, " mw"}, 32'(ex_mw), 32'(m.mw));
  endtask

  task automatic clr_fwd();
    exm_rw = 0; exm_rd = 0; exm_rslt = 0;
    mwb_rw = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  initial begin
    vt[0] = '{5, 7, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 5, 7, 7};
    vt[1] = '{5, 7, 0, 0, 3, 2, 0, 0, 1, 3, 'h1234, 1, 3, 'hBEEF,
              'h1234, 7, 7};
    vt[2] = '{'h55, 7, 0, 0, 0, 2, 0, 0, 1, 0, 'h1234, 1, 0, 'hBEEF,
              'h55, 7, 7};
    vt[3] = '{'h10, 7, 0, 0, 6, 2, 0, 0, 1, 5, 'h1, 1, 6, 'hBEEF,
              'hBEEF, 7, 7};
    vt[4] = '{'h10, 7, 'hFFFFFFF0, 0, 1, 2, 1, 0, 1, 2, 'h99, 0, 0, 0,
              'h10, 'hFFFFFFF0, 'h99};
    vt[5] = '{'h10, 'h80, 'hABCD, 4, 1, 2, 1, 1, 0, 0, 0, 1, 2, 'h77,
              'h77, 4, 'h77};
    vt[6] = '{'h10, 7, 0, 0, 3, 2, 0, 0, 0, 3, 'h5, 1, 3, 'h42,
              'h42, 7, 7};
    vt[7] = '{'h10, 7, 0, 0, 1, 2, 0, 0, 1, 2, 'h31, 1, 2, 'h32,
              'h10, 'h31, 'h31};

    rst_n = 0; stall = 0; flush = 0;
    d = '0; m = '0;
    clr_fwd();
    d.valid = 1; d.rs = 5'd1; d.rd = 5'd1;
    #2;
    chk("reset hazard", 32'(hazard), 0);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    foreach (vt[i]) begin
      d = '0;
      d.valid = 1; d.rd = 5'd1; d.op = `ALU_ADD; d.rw = 1;
      d.rs_data = vt[i].rs_data; d.rt_data = vt[i].rt_data;
      d.imm = vt[i].imm; d.shamt = vt[i].shamt;
      d.rs = vt[i].rs; d.rt = vt[i].rt;
      d.use_imm = vt[i].use_imm; d.shift = vt[i].shift;
      clr_fwd();
      tick();
      exm_rw = vt[i].exm_rw; exm_rd = vt[i].exm_rd;
      exm_rslt = vt[i].exm_rslt;
      mwb_rw = vt[i].mwb_rw; mwb_rd = vt[i].mwb_rd;
      mwb_data = vt[i].mwb_data;
      #1;
      chk($sformatf("vec%0d arg_a", i), arg_a, vt[i].ea);
      chk($sformatf("vec%0d arg_b", i), arg_b, vt[i].eb);
      chk($sformatf("vec%0d store", i), sdata, vt[i].esd);
      if (i == 0) begin
        chk("vec0 valid", 32'(ex_valid), 1);
        chk("vec0 rw", 32'(ex_rw), 1);
        chk("vec0 op", 32'(alu_op), 32'(`ALU_ADD));
      end
    end

    // load-use: rs match, then rt match gated by uses_rt
    clr_fwd();
    d = '0;
    d.valid = 1; d.mr = 1; d.rw = 1; d.rd = 5'd4;
    d.rs = 5'd1; d.rt = 5'd2;
    tick();
    d = '0; d.valid = 1; d.rs = 5'd4; d.rw = 1; d.mw = 1;
    #1;
    chk("lu rs hazard", 32'(hazard), 1);
    tick();
    chk("lu bubble valid", 32'(ex_valid), 0);
    chk("lu bubble rw", 32'(ex_rw), 0);
    chk("lu bubble mw", 32'(ex_mw), 0);
    d = '0;
    d.valid = 1; d.mr = 1; d.rw = 1; d.rd = 5'd4;
    d.rs = 5'd1; d.rt = 5'd2;
    tick();
    d = '0; d.valid = 1; d.rs = 5'd1; d.rt = 5'd4; d.uses_rt = 0;
    #1;
    chk("lu rt unused", 32'(hazard), 0);
    d.uses_rt = 1;
    #1;
    chk("lu rt used", 32'(hazard), 1);
    d.valid = 0;
    #1;
    chk("lu id invalid", 32'(hazard), 0);
    tick();

    // stall holds contents while decode churns
    d = '0;
    d.valid = 1; d.rs_data = 'h11; d.rt_data = 'h22; d.rd = 5'd9;
    d.rw = 1; d.op = 4'd3; d.rs = 5'd1; d.rt = 5'd2;
    tick();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      d.rs_data = $urandom; d.rd = 5'($urandom_range(10, 31));
      d.op = 4'($urandom_range(4, 15));
      tick();
      chk($sformatf("stall%0d rd", k), 32'(ex_rd), 9);
      chk($sformatf("stall%0d arg_a", k), arg_a, 'h11);
      chk($sformatf("stall%0d op", k), 32'(alu_op), 3);
    end
    // forwarding still tracks its inputs while frozen
    exm_rw = 1; exm_rd = 5'd1; exm_rslt = 'hCAFE;
    #1;
    chk("stall fwd", arg_a, 'hCAFE);
    clr_fwd();
    flush = 1;
    tick();
    chk("flush+stall valid", 32'(ex_valid), 0);
    chk("flush+stall rw", 32'(ex_rw), 0);
    chk("flush+stall rd", 32'(ex_rd), 0);
    flush = 0; stall = 0;

    // asynchronous reset mid-cycle
    d = '0;
    d.valid = 1; d.rs_data = 'h5A; d.rd = 5'd7; d.rw = 1;
    d.rs = 5'd3; d.op = 4'd2;
    tick();
    chk("pre-rst arg_a", arg_a, 'h5A);
    #2;
    rst_n = 0;
    m = '0;
    #1;
    chk("async rst valid", 32'(ex_valid), 0);
    chk("async rst arg_a", arg_a, 0);
    chk("async rst rd", 32'(ex_rd), 0);
    chk("async rst rw", 32'(ex_rw), 0);
    #1;
    rst_n = 1;
    d.rs_data = 'h66; d.rd = 5'd8;
    tick();
    chk("post-rst arg_a", arg_a, 'h66);
    chk("post-rst rd", 32'(ex_rd), 8);
    chk("post-rst valid", 32'(ex_valid), 1);

    for (int n = 0; n < 400; n++) begin
      d.valid = ($urandom_range(0, 3) != 0);
      d.rs_data = $urandom; d.rt_data = $urandom;
      d.imm = $urandom; d.shamt = 5'($urandom);
      d.rs = 5'($urandom_range(0, 3));
      d.rt = 5'($urandom_range(0, 3));
      d.rd = 5'($urandom_range(0, 3));
      d.op = 4'($urandom);
      d.use_imm = 1'($urandom); d.shift = ($urandom_range(0, 3) == 0);
      d.uses_rt = 1'($urandom);
      d.rw = 1'($urandom); d.mr = 1'($urandom); d.mw = 1'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      chk($sformatf("rnd%0d hazard", n), 32'(hazard),
          32'(model_hz()));
      tick();
      exm_rw = 1'($urandom); exm_rd = 5'($urandom_range(0, 3));
      exm_rslt = $urandom;
      mwb_rw = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3));
      mwb_data = $urandom;
      #1;
      check_outputs($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
